// File: rtl/gpio_ip.sv
// gpio_ip: a single software-writable output register that drives the GPIO pins
// and can be read back through a registered read port.
module gpio_ip #(
  parameter int unsigned    WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             write_en,
  input  logic             read_en,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [WIDTH-1:0] gpio_out
);

  logic [WIDTH-1:0] gpio_reg;
  logic [WIDTH-1:0] rdata_reg;

  // Output register: the pins come straight from a flop, so they never glitch.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      gpio_reg <= RESET_VAL;
    end else if (write_en) begin
      gpio_reg <= wdata;
    end
  end

  // A read in the same cycle as a write returns the value from before the write.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rdata_reg <= '0;
    end else if (read_en) begin
      rdata_reg <= gpio_reg;
    end
  end

  assign gpio_out = gpio_reg;
  assign rdata    = rdata_reg;

endmodule

// File: tb/tb_gpio_ip.sv
// tb_gpio_ip: directed and randomized checks of gpio_ip against a simple
// register-and-readback model.
module tb_gpio_ip;

  logic        clk;
  logic        resetn;
  logic        write_en;
  logic        read_en;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [31:0] gpio_out;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: what software expects the pins and the read port to show.
  logic [31:0] exp_gpio;
  logic [31:0] exp_rdata;

  gpio_ip #(.WIDTH(32), .RESET_VAL(32'h0)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .write_en (write_en),
    .read_en  (read_en),
    .wdata    (wdata),
    .rdata    (rdata),
    .gpio_out (gpio_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one bus cycle, let the edge pass, then advance the model.
  task automatic drive_cycle(input logic rn, input logic we, input logic re,
                             input logic [31:0] wd);
    @(negedge clk);
    resetn   = rn;
    write_en = we;
    read_en  = re;
    wdata    = wd;
    @(posedge clk);
    #1;
    if (!rn) begin
      exp_gpio  = 32'h0;
      exp_rdata = 32'h0;
    end else begin
      if (re) exp_rdata = exp_gpio;
      if (we) exp_gpio  = wd;
    end
  endtask

  task automatic test_reset();
    drive_cycle(1'b0, 1'b1, 1'b1, 32'hFFFF_0000);
    drive_cycle(1'b0, 1'b0, 1'b0, 32'h0);
    n_checks++;
    if (gpio_out !== 32'h0) begin
      n_fail++;
      $display("[TB] FAIL reset_gpio: got %h expected %h", gpio_out, 32'h0);
    end
    n_checks++;
    if (rdata !== 32'h0) begin
      n_fail++;
      $display("[TB] FAIL reset_rdata: got %h expected %h", rdata, 32'h0);
    end
  endtask

  task automatic test_write();
    drive_cycle(1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF);
    n_checks++;
    if (gpio_out !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("[TB] FAIL write_gpio: got %h expected %h", gpio_out, 32'hDEAD_BEEF);
    end
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1'b1, 1'b0, 1'b0, 32'h1111_1111 * (i + 1));
      n_checks++;
      if (gpio_out !== 32'hDEAD_BEEF) begin
        n_fail++;
        $display("[TB] FAIL write_hold: got %h expected %h", gpio_out, 32'hDEAD_BEEF);
      end
    end
    n_checks++;
    if (rdata !== 32'h0) begin
      n_fail++;
      $display("[TB] FAIL rdata_no_read: got %h expected %h", rdata, 32'h0);
    end
  endtask

  task automatic test_read();
    drive_cycle(1'b1, 1'b0, 1'b1, 32'h0);
    n_checks++;
    if (rdata !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("[TB] FAIL read: got %h expected %h", rdata, 32'hDEAD_BEEF);
    end
  endtask

  task automatic test_simultaneous();
    drive_cycle(1'b1, 1'b1, 1'b1, 32'h1234_5678);
    n_checks++;
    if (rdata !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("[TB] FAIL simul_rdata_old: got %h expected %h", rdata, 32'hDEAD_BEEF);
    end
    n_checks++;
    if (gpio_out !== 32'h1234_5678) begin
      n_fail++;
      $display("[TB] FAIL simul_gpio_new: got %h expected %h", gpio_out, 32'h1234_5678);
    end
    // rdata must hold while no read is issued, even though the register changed.
    drive_cycle(1'b1, 1'b0, 1'b0, 32'h0);
    n_checks++;
    if (rdata !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("[TB] FAIL rdata_hold: got %h expected %h", rdata, 32'hDEAD_BEEF);
    end
    drive_cycle(1'b1, 1'b0, 1'b1, 32'h0);
    n_checks++;
    if (rdata !== 32'h1234_5678) begin
      n_fail++;
      $display("[TB] FAIL simul_next_read: got %h expected %h", rdata, 32'h1234_5678);
    end
  endtask

  task automatic test_back_to_back();
    drive_cycle(1'b1, 1'b1, 1'b0, 32'hA5A5_A5A5);
    n_checks++;
    if (gpio_out !== 32'hA5A5_A5A5) begin
      n_fail++;
      $display("[TB] FAIL b2b_first: got %h expected %h", gpio_out, 32'hA5A5_A5A5);
    end
    drive_cycle(1'b1, 1'b1, 1'b0, 32'h5A5A_5A5A);
    n_checks++;
    if (gpio_out !== 32'h5A5A_5A5A) begin
      n_fail++;
      $display("[TB] FAIL b2b_second: got %h expected %h", gpio_out, 32'h5A5A_5A5A);
    end
  endtask

  // Read held high across a run of writes: rdata lags the register by one edge.
  task automatic test_read_hold();
    logic [31:0] prev;
    prev = exp_gpio;
    for (int i = 0; i < 6; i++) begin
      logic [31:0] v;
      v = $urandom;
      drive_cycle(1'b1, 1'b1, 1'b1, v);
      n_checks++;
      if (rdata !== prev || gpio_out !== v) begin
        n_fail++;
        $display("[TB] FAIL read_track: rdata %h gpio %h expected rdata %h gpio %h",
                 rdata, gpio_out, prev, v);
      end
      prev = v;
    end
  endtask

  task automatic test_reset_override();
    drive_cycle(1'b1, 1'b1, 1'b1, 32'h5A5A_5A5A);
    drive_cycle(1'b1, 1'b0, 1'b1, 32'h0);
    drive_cycle(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF);
    n_checks++;
    if (gpio_out !== 32'h0) begin
      n_fail++;
      $display("[TB] FAIL reset_override_gpio: got %h expected %h", gpio_out, 32'h0);
    end
    n_checks++;
    if (rdata !== 32'h0) begin
      n_fail++;
      $display("[TB] FAIL reset_override_rdata: got %h expected %h", rdata, 32'h0);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      logic rn;
      rn = ($urandom_range(0, 15) != 0);
      drive_cycle(rn, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
      n_checks++;
      if (gpio_out !== exp_gpio || rdata !== exp_rdata) begin
        n_fail++;
        $display("[TB] FAIL random[%0d]: gpio %h rdata %h expected gpio %h rdata %h",
                 i, gpio_out, rdata, exp_gpio, exp_rdata);
      end
    end
  endtask

  initial begin
    resetn    = 1'b0;
    write_en  = 1'b0;
    read_en   = 1'b0;
    wdata     = 32'h0;
    exp_gpio  = 32'h0;
    exp_rdata = 32'h0;
    test_reset();
    test_write();
    test_read();
    test_simultaneous();
    test_back_to_back();
    test_read_hold();
    test_reset_override();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
